// File: rtl/icache_dm.sv
`default_nettype none
// ============================================================================
//  Module   : icache_dm
//  Purpose  : Direct-mapped, read-only instruction cache. Returns hits in the
//             same cycle. On a miss it holds cpu_ready low while the whole
//             line is refilled from backing memory as a burst. Also provides
//             a whole-cache invalidate and saturating hit/miss counters.
//  Ports    : clk, rst_n (synchronous, active low)
//             cpu_addr/cpu_rd -> cpu_rdata/cpu_ready   fetch port
//             flush                                     invalidate all lines
//             mem_req/mem_addr <- mem_gnt               refill request
//             mem_rvalid/mem_rdata                      refill data beats
//             hit_cnt/miss_cnt                          saturating counters
//  Revision : 1.0  initial release
// ============================================================================
module icache_dm #(
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_rd,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_ready,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
);

    localparam int c_OFF_W   = $clog2(WORDS_PER_LINE);
    localparam int c_IDX_W   = $clog2(LINES);
    localparam int c_IDX_LSB = c_OFF_W + 2;
    localparam int c_TAG_W   = ADDR_W - c_IDX_LSB - c_IDX_W;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_FILL = 2'd2;

    logic [1:0]          r_state;
    logic [LINES-1:0]    r_valid;
    logic [c_TAG_W-1:0]  r_tag  [LINES];
    logic [31:0]         r_data [LINES][WORDS_PER_LINE];
    logic [c_OFF_W-1:0]  r_beat;
    logic                r_flush_pend;
    logic                r_mem_req;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [31:0]         r_hit_cnt;
    logic [31:0]         r_miss_cnt;

    logic [c_OFF_W-1:0]  w_off;
    logic [c_IDX_W-1:0]  w_idx;
    logic [c_TAG_W-1:0]  w_tag;
    logic [c_IDX_W-1:0]  w_fill_idx;
    logic [c_TAG_W-1:0]  w_fill_tag;
    logic                w_hit;
    logic                w_lookup_hit;
    logic                w_miss;
    logic                w_beat_wr;
    logic                w_last_beat;
    logic                w_unused_addr_bits;

    // Lookup fields come from the live fetch address; the refill target comes
    // from the latched line address so a wandering cpu_addr cannot redirect
    // an in-flight refill.
    assign w_off      = cpu_addr[2 +: c_OFF_W];
    assign w_idx      = cpu_addr[c_IDX_LSB +: c_IDX_W];
    assign w_tag      = cpu_addr[ADDR_W-1 -: c_TAG_W];
    assign w_fill_idx = r_mem_addr[c_IDX_LSB +: c_IDX_W];
    assign w_fill_tag = r_mem_addr[ADDR_W-1 -: c_TAG_W];

    assign w_hit        = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_lookup_hit = (r_state == c_IDLE) && cpu_rd && w_hit;
    assign w_miss       = (r_state == c_IDLE) && cpu_rd && !w_hit;
    assign w_beat_wr    = (r_state == c_FILL) && mem_rvalid;
    // WORDS_PER_LINE is a power of two, so the last beat is the all-ones count.
    assign w_last_beat  = w_beat_wr && (&r_beat);

    assign w_unused_addr_bits = ^cpu_addr[1:0];

    assign cpu_ready = w_lookup_hit;
    assign cpu_rdata = r_data[w_idx][w_off];
    assign mem_req   = r_mem_req;
    assign mem_addr  = r_mem_addr;
    assign hit_cnt   = r_hit_cnt;
    assign miss_cnt  = r_miss_cnt;

    // Control state, valid bits and counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            r_valid      <= '0;
            r_beat       <= '0;
            r_flush_pend <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_hit_cnt    <= '0;
            r_miss_cnt   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (flush) begin
                        r_valid <= '0;
                    end
                    if (w_miss) begin
                        r_mem_addr <= {cpu_addr[ADDR_W-1:c_IDX_LSB], {c_IDX_LSB{1'b0}}};
                        r_mem_req  <= 1'b1;
                        r_state    <= c_REQ;
                    end
                end
                c_REQ: begin
                    if (flush) begin
                        r_flush_pend <= 1'b1;
                    end
                    if (mem_gnt) begin
                        r_mem_req <= 1'b0;
                        r_beat    <= '0;
                        r_state   <= c_FILL;
                    end
                end
                c_FILL: begin
                    if (flush) begin
                        r_flush_pend <= 1'b1;
                    end
                    if (w_beat_wr) begin
                        // Increment wraps the counter back to zero on the last beat.
                        r_beat <= r_beat + c_OFF_W'(1);
                    end
                    if (w_last_beat) begin
                        // A flush seen at any point during the refill (including
                        // this cycle) invalidates everything, the new line too.
                        if (r_flush_pend || flush) begin
                            r_valid <= '0;
                        end else begin
                            r_valid[w_fill_idx] <= 1'b1;
                        end
                        r_flush_pend <= 1'b0;
                        r_state      <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase

            if (w_lookup_hit && (r_hit_cnt != 32'hFFFF_FFFF)) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end
            if (w_miss && (r_miss_cnt != 32'hFFFF_FFFF)) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    // Tag and data storage: contents are meaningless until the valid bit is
    // set, so no reset is applied; writes are still blocked during reset so
    // that beats arriving then cannot land anywhere.
    always_ff @(posedge clk) begin
        if (rst_n && w_beat_wr) begin
            r_data[w_fill_idx][r_beat] <= mem_rdata;
            if (&r_beat) begin
                r_tag[w_fill_idx] <= w_fill_tag;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_icache_dm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_icache_dm
//  Purpose  : Self-checking bench for icache_dm. A table of fetch vectors
//             (address, expected hit/miss, grant delay, beat gap) drives the
//             cache while the bench plays the backing memory; expected words
//             are queued when a fetch starts and compared when cpu_ready rises.
//             Hand-written sequences cover flush, reset mid-refill and counter
//             saturation.
//  Revision : 1.0  initial release
// ============================================================================
module tb_icache_dm;

    logic        clk;
    logic        rst_n;
    logic [31:0] cpu_addr;
    logic        cpu_rd;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    int checks   = 0;
    int failures = 0;

    logic [31:0] sb_q[$];
    logic [31:0] exp_hit_cnt;
    logic [31:0] exp_miss_cnt;

    typedef struct {
        logic [31:0] addr;
        bit          hit;
        int          gnt_delay;
        int          gap;
    } vec_t;

    vec_t vecs[13];

    icache_dm #(
        .LINES          (16),
        .WORDS_PER_LINE (4),
        .ADDR_W         (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_addr   (cpu_addr),
        .cpu_rd     (cpu_rd),
        .cpu_rdata  (cpu_rdata),
        .cpu_ready  (cpu_ready),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backing memory contents: word at 0x10 is 0xA0, 0x1C is 0xA3, etc.
    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return 32'h9C + (a >> 2);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk_cnt(input string name);
        chk({name, "_hit_cnt"}, hit_cnt, exp_hit_cnt);
        chk({name, "_miss_cnt"}, miss_cnt, exp_miss_cnt);
    endtask

    // Wait (bounded) for cpu_ready, then compare against the queued word.
    task automatic wait_pop(input string name);
        int n;
        logic [31:0] e;
        n = 0;
        #1;
        while (!cpu_ready && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        e = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hxxxx_xxxx;
        if (!cpu_ready) chk({name, "_ready_timeout"}, {31'd0, cpu_ready}, 32'd1);
        else            chk({name, "_rdata"}, cpu_rdata, e);
    endtask

    // Play the backing memory for one line. Called at the negedge where the
    // cache is in REQ. Returns at the negedge after the last beat edge, or
    // right after a reset pulse if rst_beat matches.
    task automatic refill(input logic [31:0] line, input int gd, input int gap,
                          input int flush_beat, input int rst_beat);
        repeat (gd) begin
            @(negedge clk);
            chk("stall_req", {31'd0, mem_req}, 32'd1);
            chk("stall_ready", {31'd0, cpu_ready}, 32'd0);
        end
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("req_drop", {31'd0, mem_req}, 32'd0);
        for (int b = 0; b < 4; b++) begin
            repeat (gap) begin
                @(negedge clk);
                chk("gap_ready", {31'd0, cpu_ready}, 32'd0);
            end
            mem_rvalid = 1'b1;
            mem_rdata  = mem_val(line + 32'(4 * b));
            @(negedge clk);
            mem_rvalid = 1'b0;
            mem_rdata  = 32'hDEAD_0000;
            if (b == flush_beat) begin
                flush = 1'b1;
                @(negedge clk);
                flush = 1'b0;
            end
            if (b == rst_beat) begin
                rst_n  = 1'b0;
                cpu_rd = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
        end
    endtask

    // One fetch: hit expected now, or a full miss/refill followed by a hit.
    task automatic access(input logic [31:0] a, input bit exp_hit, input int gd, input int gap);
        sb_q.push_back(mem_val(a));
        cpu_addr = a;
        cpu_rd   = 1'b1;
        #1;
        chk($sformatf("ready_now_%h", a), {31'd0, cpu_ready}, {31'd0, exp_hit});
        if (!exp_hit) begin
            exp_miss_cnt = sat_inc(exp_miss_cnt);
            @(negedge clk);
            chk($sformatf("mem_req_%h", a), {31'd0, mem_req}, 32'd1);
            chk($sformatf("mem_addr_%h", a), mem_addr, a & 32'hFFFF_FFF0);
            refill(a & 32'hFFFF_FFF0, gd, gap, -1, -1);
        end
        wait_pop($sformatf("fetch_%h", a));
        exp_hit_cnt = sat_inc(exp_hit_cnt);
        @(negedge clk);
        cpu_rd = 1'b0;
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        vecs[0]  = '{32'h0000_0010, 1'b0, 0, 0};  // cold miss, beats 0xA0..0xA3
        vecs[1]  = '{32'h0000_001C, 1'b1, 0, 0};  // last word same line -> 0xA3
        vecs[2]  = '{32'h0000_0014, 1'b1, 0, 0};
        vecs[3]  = '{32'h0000_0110, 1'b0, 1, 0};  // conflict, same index
        vecs[4]  = '{32'h0000_0010, 1'b0, 0, 1};  // evicted, misses again
        vecs[5]  = '{32'h0000_0018, 1'b1, 0, 0};
        vecs[6]  = '{32'h0000_0050, 1'b0, 5, 2};  // delayed grant, gapped beats
        vecs[7]  = '{32'h0000_005C, 1'b1, 0, 0};
        vecs[8]  = '{32'h8000_0058, 1'b0, 2, 1};  // high tag bits
        vecs[9]  = '{32'h0000_0050, 1'b0, 0, 0};
        vecs[10] = '{32'h0000_0040, 1'b0, 0, 0};
        vecs[11] = '{32'h0000_0044, 1'b1, 0, 0};
        vecs[12] = '{32'h0000_001C, 1'b1, 0, 0};  // other index untouched

        rst_n = 1'b0; cpu_addr = '0; cpu_rd = 1'b0; flush = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        exp_hit_cnt = '0; exp_miss_cnt = '0;

        // Reset state, with a fetch presented while in reset.
        repeat (2) @(negedge clk);
        cpu_addr = 32'h10; cpu_rd = 1'b1;
        #1;
        chk("rst_ready", {31'd0, cpu_ready}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk_cnt("rst");
        cpu_rd = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            access(vecs[i].addr, vecs[i].hit, vecs[i].gnt_delay, vecs[i].gap);
            chk_cnt($sformatf("vec%0d", i));
        end

        // Flush in IDLE: the flush cycle still hits from pre-flush state.
        cpu_addr = 32'h44; cpu_rd = 1'b1; flush = 1'b1;
        #1;
        chk("flush_idle_ready", {31'd0, cpu_ready}, 32'd1);
        chk("flush_idle_rdata", cpu_rdata, mem_val(32'h44));
        exp_hit_cnt = sat_inc(exp_hit_cnt);
        @(negedge clk);
        flush = 1'b0; cpu_rd = 1'b0;
        access(32'h44, 1'b0, 0, 0);
        access(32'h1C, 1'b0, 0, 0);
        chk_cnt("flush_idle");

        // Flush during FILL of 0x20: line left invalid, FSM re-misses, and
        // the previously valid line at 0x40 is gone as well.
        cpu_addr = 32'h20; cpu_rd = 1'b1;
        #1;
        chk("ff_ready0", {31'd0, cpu_ready}, 32'd0);
        exp_miss_cnt = sat_inc(exp_miss_cnt);
        @(negedge clk);
        chk("ff_mem_addr", mem_addr, 32'h20);
        refill(32'h20, 0, 0, 1, -1);
        #1;
        chk("ff_line_invalid", {31'd0, cpu_ready}, 32'd0);
        sb_q.push_back(mem_val(32'h20));
        exp_miss_cnt = sat_inc(exp_miss_cnt);
        @(negedge clk);
        chk("ff_remiss_req", {31'd0, mem_req}, 32'd1);
        refill(32'h20, 0, 0, -1, -1);
        wait_pop("ff_refetch");
        exp_hit_cnt = sat_inc(exp_hit_cnt);
        @(negedge clk);
        cpu_rd = 1'b0;
        access(32'h40, 1'b0, 0, 0);
        chk_cnt("flush_fill");

        // Reset after beat 2 of a refill of 0x30.
        cpu_addr = 32'h30; cpu_rd = 1'b1;
        #1;
        @(negedge clk);
        chk("rf_mem_req", {31'd0, mem_req}, 32'd1);
        refill(32'h30, 0, 0, -1, 2);
        exp_hit_cnt = '0; exp_miss_cnt = '0;
        cpu_addr = 32'h30; cpu_rd = 1'b1;
        #1;
        chk("rf_mem_req0", {31'd0, mem_req}, 32'd0);
        chk("rf_mem_addr0", mem_addr, 32'd0);
        chk("rf_ready0", {31'd0, cpu_ready}, 32'd0);
        chk_cnt("rf");
        cpu_rd = 1'b0;
        repeat (3) begin
            mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
            @(negedge clk);
        end
        mem_rvalid = 1'b0;
        chk("rf_stray_req", {31'd0, mem_req}, 32'd0);
        access(32'h10, 1'b0, 0, 0);
        access(32'h30, 1'b0, 0, 0);
        chk_cnt("rf_after");

        // Saturation of the hit counter from a preloaded value.
        force dut.r_hit_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_hit_cnt;
        exp_hit_cnt = 32'hFFFF_FFFE;
        chk("sat_preload", hit_cnt, exp_hit_cnt);
        for (int k = 0; k < 3; k++) begin
            access(32'h14, 1'b1, 0, 0);
            chk_cnt($sformatf("sat%0d", k));
        end
        chk("sat_hold", hit_cnt, 32'hFFFF_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache between the fetch stage's instruction-memory port and a backing memory.
- Hits return the instruction word in the same cycle.
- Misses hold cpu_ready low while a full line is refilled by burst, then the line hits.
- Provides whole-cache invalidate and saturating hit/miss counters for performance analysis.

Parameters:
- LINES, 16, number of cache lines; power of 2, at least 2.
- WORDS_PER_LINE, 4, 32-bit words per line; power of 2, at least 2.
- ADDR_W, 32, byte address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- cpu_addr  in  ADDR_W  fetch byte address; bits [1:0] ignored.
- cpu_rd  in  1  fetch request.
- cpu_rdata  out  32  instruction word.
- cpu_ready  out  1  cpu_rdata valid for cpu_addr this cycle.
- flush  in  1  invalidate all lines (single-cycle pulse).
- mem_req  out  1  line refill request.
- mem_addr  out  ADDR_W  line-aligned refill address.
- mem_gnt  in  1  backing memory accepted request.
- mem_rvalid  in  1  refill data beat valid.
- mem_rdata  in  32  refill data beat.
- hit_cnt  out  32  saturating hit counter.
- miss_cnt  out  32  saturating miss counter.

Behaviour:
- Address split, defaults shown:
  - word offset = cpu_addr[3:2]
  - index = cpu_addr[7:4]
  - tag = cpu_addr[ADDR_W-1:8]
  - Widths follow from log2(WORDS_PER_LINE) and log2(LINES).
- Storage is flop arrays with a per-line valid bit, tag and data words; reads are combinational.
- hit = valid[index] && tag match.
- FSM states: IDLE, REQ, FILL.
  - IDLE:
    - cpu_ready = cpu_rd && hit; cpu_rdata = data[index][offset]. Zero-cycle hit latency.
    - cpu_rd && !hit -> latch line address (cpu_addr with offset bits and [1:0] zeroed) into mem_addr; go to REQ.
    - cpu_rd low -> cpu_ready 0; no state change.
  - REQ:
    - mem_req = 1; mem_addr held stable.
    - mem_gnt -> go to FILL with beat counter = 0.
    - mem_req deasserts in the cycle after the grant edge.
  - FILL:
    - Each mem_rvalid writes mem_rdata into word[beat] of the latched index and increments beat. Gaps between beats are allowed.
    - On the last beat (beat == WORDS_PER_LINE-1): write the tag, set valid (unless a flush is pending), go to IDLE.
    - The access hits on the following cycle.
    - mem_rvalid is ignored outside FILL; mem_gnt is ignored outside REQ.
- cpu_ready = 0 in REQ and FILL.
- The requester holds cpu_addr stable while cpu_ready = 0. If cpu_addr changes anyway, the refill completes for the latched line; the new address is looked up afterwards in IDLE.
- cpu_rdata is don't-care whenever cpu_ready = 0; the implementation drives data[index][offset].
- Flush:
  - In IDLE: all valid bits clear at the next edge. cpu_ready is still computed from pre-flush state in the flush cycle.
  - In REQ/FILL: flush is recorded as pending. The refill runs to completion with the filled line left invalid, and all valid bits clear on the final-beat edge; the FSM then re-misses.
- Counters:
  - hit_cnt increments on each IDLE cycle with cpu_rd && hit.
  - miss_cnt increments on each IDLE->REQ transition.
  - Both saturate at 32'hFFFF_FFFF.
- Reset (rst_n low at a clock edge, from any state, including mid-refill):
  - FSM -> IDLE; all valid bits 0; flush-pending 0; beat counter 0.
  - mem_req = 0; mem_addr = 0; hit_cnt = 0; miss_cnt = 0.
  - cpu_ready = 0 (nothing valid).
  - Tag and data arrays need not be reset.
  - Beats arriving after reset are ignored.
- Wrap-around: the beat counter wraps to 0 on leaving FILL. Index aliasing: a miss on a valid line overwrites it (no victim write-back; read-only).

Test Plan:
- Cold miss: reset, cpu_rd=1, cpu_addr=0x0000_0010.
  - Expect mem_req=1 with mem_addr=0x10; grant; 4 beats 0xA0..0xA3.
  - Next cycle cpu_ready=1, cpu_rdata=0xA0; addr 0x1C gives 0xA3 same cycle. miss_cnt=1, hit_cnt=2.
- Conflict: fill 0x10, then access 0x110 (same index, different tag).
  - Expect miss and refill, mem_addr=0x110. Re-access 0x10 -> miss again; miss_cnt=3.
- Beat gaps and stall: fill with mem_rvalid pulsing every third cycle and mem_gnt delayed 5 cycles.
  - cpu_ready stays 0 throughout; line correct afterwards.
- Flush mid-FILL: assert flush after beat 1 of a refill of 0x20.
  - Refill completes; 0x20 re-misses next cycle; a previously valid line at 0x40 also misses.
- Reset mid-FILL: drop rst_n after beat 2.
  - mem_req=0, counters=0, FSM IDLE; stray mem_rvalid beats ignored; 0x10 misses.
- Saturation: force hit_cnt near 0xFFFF_FFFE via 3 hits on preloaded counters, or run a long loop in simulation.
  - Counter holds at 0xFFFF_FFFF.
